// File: rtl/modarith_host_seq_if.sv
// Core-side bus of the MADD_MSUB modular add/subtract core: load bus, strobes, read-back and status.
interface modarith_host_seq_if #(
  parameter int unsigned DW = 16
);
  logic [DW-1:0] datain;
  logic          loada;
  logic          loadb;
  logic          loadp;
  logic          madd_en;
  logic          msub_en;
  logic          outs0;
  logic          outs1;
  logic [DW-1:0] regs0out;
  logic [DW-1:0] regs1out;
  logic          result_rdy;
  logic          result_flag;

  // Sequencer side
  modport master (
    output datain, loada, loadb, loadp, madd_en, msub_en, outs0, outs1,
    input  regs0out, regs1out, result_rdy, result_flag
  );

  // Core side
  modport slave (
    input  datain, loada, loadb, loadp, madd_en, msub_en, outs0, outs1,
    output regs0out, regs1out, result_rdy, result_flag
  );
endinterface

// File: rtl/modarith_host_seq.sv
// Host sequencer for the MADD_MSUB core: serialises a/b/p onto the 16-bit load bus,
// fires the operation, waits for result_rdy (with timeout) and collects the result.
module modarith_host_seq #(
  parameter int unsigned W       = 256,
  parameter int unsigned DW      = 16,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic         load_p,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic [W-1:0] p_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result,
  output logic         result_flag_o,
  modarith_host_seq_if.master core
);
  localparam int unsigned NW = W / DW;
  localparam int unsigned IW = $clog2(NW);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_P, S_START, S_WAIT, S_READ, S_DRAIN
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [IW-1:0] wcap;
  logic [IW-1:0] widx_c;
  logic [W-1:0]  a_sh, b_sh, p_sh, res_sh;
  logic [W-1:0]  a_nx_c, res_ins_c;
  logic          op_sh, lp_sh;
  logic [RD_LAT-1:0] samp_sr;
  logic          accept_c, last_c, cap_c;
  logic [DW-1:0] rd_word_c;

  logic          busy_d, done_d, err_d;
  logic [DW-1:0] datain_d, datain_q;
  logic          loada_d, loadb_d, loadp_d, madd_en_d, msub_en_d, outs0_d, outs1_d;
  logic          loada_q, loadb_q, loadp_q, madd_en_q, msub_en_q, outs0_q, outs1_q;

  assign core.datain  = datain_q;
  assign core.loada   = loada_q;
  assign core.loadb   = loadb_q;
  assign core.loadp   = loadp_q;
  assign core.madd_en = madd_en_q;
  assign core.msub_en = msub_en_q;
  assign core.outs0   = outs0_q;
  assign core.outs1   = outs1_q;

  // Next state plus next values of all registered outputs (decoded from the next state)
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    done_d    = 1'b0;
    err_d     = 1'b0;
    accept_c  = (state == S_IDLE) && start;
    last_c    = (cnt == CW'(NW - 1));
    cap_c     = samp_sr[RD_LAT-1];
    rd_word_c = op_sh ? core.regs1out : core.regs0out;
    res_ins_c = res_sh;
    res_ins_c[int'(wcap)*DW +: DW] = rd_word_c;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_A;
          cnt_d   = '0;
        end
      end
      S_LOAD_A: begin
        if (last_c) begin
          state_d = S_LOAD_B;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_LOAD_B: begin
        if (last_c) begin
          state_d = lp_sh ? S_LOAD_P : S_START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_LOAD_P: begin
        if (last_c) begin
          state_d = S_START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (core.result_rdy) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_READ: begin
        if (last_c) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cap_c && (wcap == IW'(NW - 1))) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // The first word of a must come straight from a_in: the shadow loads on the same edge
    a_nx_c    = accept_c ? a_in : a_sh;
    widx_c    = cnt_d[IW-1:0];
    datain_d  = '0;
    loada_d   = 1'b0;
    loadb_d   = 1'b0;
    loadp_d   = 1'b0;
    madd_en_d = 1'b0;
    msub_en_d = 1'b0;
    outs0_d   = 1'b0;
    outs1_d   = 1'b0;
    case (state_d)
      S_LOAD_A: begin
        loada_d  = 1'b1;
        datain_d = a_nx_c[int'(widx_c)*DW +: DW];
      end
      S_LOAD_B: begin
        loadb_d  = 1'b1;
        datain_d = b_sh[int'(widx_c)*DW +: DW];
      end
      S_LOAD_P: begin
        loadp_d  = 1'b1;
        datain_d = p_sh[int'(widx_c)*DW +: DW];
      end
      S_START: begin
        madd_en_d = ~op_sh;
        msub_en_d = op_sh;
      end
      S_READ: begin
        outs0_d = ~op_sh;
        outs1_d = op_sh;
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Operand shadows, read-back collection and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh          <= '0;
      b_sh          <= '0;
      p_sh          <= '0;
      res_sh        <= '0;
      op_sh         <= 1'b0;
      lp_sh         <= 1'b0;
      wcap          <= '0;
      samp_sr       <= '0;
      result        <= '0;
      result_flag_o <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      datain_q      <= '0;
      loada_q       <= 1'b0;
      loadb_q       <= 1'b0;
      loadp_q       <= 1'b0;
      madd_en_q     <= 1'b0;
      msub_en_q     <= 1'b0;
      outs0_q       <= 1'b0;
      outs1_q       <= 1'b0;
    end else begin
      samp_sr <= RD_LAT'({samp_sr, outs0_q | outs1_q});
      if (cap_c) begin
        res_sh <= res_ins_c;
        wcap   <= wcap + IW'(1);
      end
      if (accept_c) begin
        a_sh  <= a_in;
        b_sh  <= b_in;
        p_sh  <= p_in;
        op_sh <= op;
        lp_sh <= load_p;
        wcap  <= '0;
      end
      if ((state == S_WAIT) && core.result_rdy) begin
        result_flag_o <= core.result_flag;
      end
      if (done_d && !err_d) begin
        result <= res_ins_c;
      end
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      datain_q  <= datain_d;
      loada_q   <= loada_d;
      loadb_q   <= loadb_d;
      loadp_q   <= loadp_d;
      madd_en_q <= madd_en_d;
      msub_en_q <= msub_en_d;
      outs0_q   <= outs0_d;
      outs1_q   <= outs1_d;
    end
  end
endmodule

// File: doc/modarith_host_seq.md
Name: modarith_host_seq

Overview:
- Host-side sequencer for the MADD_MSUB modular add/subtract core.
- Takes full-width operands a, b, p plus an operation select.
- Serialises the operands onto the core's 16-bit load bus, LS word first, then pulses the operation enable.
- Waits for result_rdy, reads the 256-bit result back 16 bits per cycle, and presents it in parallel with a done pulse.

Parameters:
- W, 256, operand/result width in bits.
- DW, 16, core data-bus width; NW = W/DW words per operand (16).
- RD_LAT, 1, cycles from outs0/outs1 asserted to the first valid word on regs0out/regs1out.
- TIMEOUT, 1023, maximum WAIT cycles before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  1  0 = modular add (madd_en), 1 = modular subtract (msub_en).
- load_p  in  1  1 = reload modulus; 0 = skip LOAD_P and reuse the core's stored p.
- a_in, b_in, p_in  in  W  operands, captured on accepted start.
- busy  out  1  high from accepted start until the cycle done is asserted.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = timeout abort.
- result  out  W  collected result; held until the next done.
- result_flag_o  out  1  core result_flag captured when result_rdy is seen.
- datain  out  DW  core load bus.
- loada, loadb, loadp  out  1  core load strobes.
- madd_en, msub_en  out  1  core operation enables.
- outs0, outs1  out  1  core read strobes (outs0 selects the add result, outs1 the subtract result).
- regs0out, regs1out  in  DW  core result words.
- result_rdy, result_flag  in  1  core status.

Behaviour:
- Reset: all outputs are 0, including result and datain. FSM goes to IDLE; counters clear. Reset mid-operation abandons the transfer; no done is issued.
- start in IDLE: latch a_in, b_in, p_in, op and load_p into shadow registers; busy = 1; go to LOAD_A. start is ignored while busy.
- LOAD_A: 16 consecutive cycles with loada = 1 and datain = a[16k+15:16k] for k = 0..15, then go to LOAD_B. No idle gap between words or between phases.
- LOAD_B: same as LOAD_A, using loadb and b.
- LOAD_P: same, using loadp and p. Skipped entirely when the latched load_p = 0.
- Only one load strobe is high in any cycle.
- START: one cycle with madd_en = 1 if op = 0, else msub_en = 1; then go to WAIT.
- WAIT: count cycles.
  - On result_rdy = 1: capture result_flag into result_flag_o and go to READ.
  - If the count reaches TIMEOUT with no result_rdy: pulse done with err = 1, leave result unchanged, go to IDLE.
  - result_rdy already high in the first WAIT cycle is accepted.
- READ: assert outs0 (op = 0) or outs1 (op = 1) for exactly 16 cycles.
  - Word k is sampled from regs0out (op = 0) or regs1out (op = 1) RD_LAT cycles after the k-th strobe cycle.
  - Word k lands in result[16k+15:16k].
  - Sampling continues RD_LAT cycles after the strobe drops.
- DONE: after word 15 is written, pulse done = 1 with err = 0 and busy = 0, update result atomically, return to IDLE.
  - result is built in a shadow register and copied to the result output on DONE.
- A new start is accepted the cycle after done.
- Total latency for a no-timeout run (load_p = 1), start to done: 48 + 1 + W_wait + 16 + RD_LAT + 1 cycles, where W_wait is the number of WAIT cycles.

Test Plan:
- madd, load_p = 1:
  - a = 32C4AE2C_1F198119_5F990446_6A39C994_8FE30BBF_F2660BE1_715A4589_334C74C7
  - b = BC3736A2_F4F6779C_59BDCEE3_6B692153_D0A9877C_C62A4740_02DF32E5_2139F0A0
  - p = FFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF
  - Required: datain shows 74C7, 334C, ... across 48 load cycles; exactly one madd_en pulse; result = (a+b) mod p; err = 0.
- msub with the same operands:
  - Required: msub_en pulses; outs1 is high for 16 cycles while outs0 stays 0; result = (a-b+p) mod p.
- load_p = 0:
  - Required: no loadp cycle occurs; the enable is asserted at cycle 33 after start.
- Core model holds result_rdy = 0:
  - Required: done with err = 1 after TIMEOUT WAIT cycles; result holds its previous value.
- start pulsed while busy, plus rst asserted during READ:
  - Required: the second start is ignored; rst returns all outputs to 0 immediately; no done pulse occurs.
- Back-to-back runs:
  - start is asserted the cycle after done.
  - Required: the second run starts LOAD_A the next cycle; result_flag_o tracks each run's result_flag.
